// File: rtl/multi_cycle_memory_responder.sv
// Memory-side responder: answers read/write requests from a word RAM after a programmable latency.
// Optional MEM_LATENCY_JITTER_EN adds 0..3 LFSR-driven extra wait cycles per request.
module multi_cycle_memory_responder #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned ADDRESS_BITS     = 32,
  parameter int unsigned MEM_ADDRESS_BITS = 14,
  parameter int unsigned LATENCY          = 3,
  parameter string       INIT_FILE        = "",
  parameter int          SCAN_CYCLES_MIN  = 0,
  parameter int          SCAN_CYCLES_MAX  = 1000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      read,
  input  logic                      write,
  input  logic [DATA_WIDTH/8-1:0]   byte_en,
  input  logic [ADDRESS_BITS-1:0]   address_in,
  input  logic [DATA_WIDTH-1:0]     data_in,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic [ADDRESS_BITS-1:0]   address_out,
  output logic                      valid,
  output logic                      ready,
  input  logic                      scan
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
  localparam int unsigned DEPTH     = 2 ** MEM_ADDRESS_BITS;
  localparam int unsigned CNT_W     = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic                    ready_q, ready_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic [ADDRESS_BITS-1:0] address_out_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    accept_c;
  logic                    direct_c;
  logic [1:0]              jitter_c;
  logic [CNT_W-1:0]        wait_len_c;
  logic [DATA_WIDTH-1:0]   wmask_c;
  logic [DATA_WIDTH-1:0]   raw_word_c;

  assign accept_c   = ready_q & (read | write);
  assign wait_len_c = CNT_W'(LATENCY - 1) + CNT_W'(jitter_c);

`ifdef MEM_LATENCY_JITTER_EN
  // Fibonacci LFSR, taps 8,6,5,4; free-running so jitter depends only on reset timing
  logic [7:0] lfsr_q;
  logic       lfsr_fb_c;

  assign lfsr_fb_c = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign jitter_c  = lfsr_q[1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_fb_c};
    end
  end
`else
  assign jitter_c = 2'b00;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: IDLE and RESP both accept; a zero wait length goes straight to RESP
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    direct_c = 1'b0;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (accept_c) begin
          addr_d = address_in;
          if (wait_len_c == '0) begin
            state_d  = S_RESP;
            direct_c = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = wait_len_c - CNT_W'(1);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d != S_WAIT);
    valid_d = (state_d == S_RESP);
  end

  // Write mask of the current request, used to form the post-write word on the direct path
  always_comb begin
    wmask_c = '0;
    for (int b = 0; b < int'(NUM_BYTES); b++) begin
      wmask_c[b*8 +: 8] = {8{write & byte_en[b]}};
    end
  end

  // The RAM is written on the acceptance edge, so only the same-edge response needs merging
  always_comb begin
    raw_word_c = mem[addr_d[MEM_ADDRESS_BITS-1:0]];
    data_out_d = raw_word_c;
    if (direct_c) begin
      data_out_d = (raw_word_c & ~wmask_c) | (data_in & wmask_c);
    end
  end

  always_ff @(posedge clock) begin
    if (accept_c && write) begin
      for (int b = 0; b < int'(NUM_BYTES); b++) begin
        if (byte_en[b]) begin
          mem[address_in[MEM_ADDRESS_BITS-1:0]][b*8 +: 8] <= data_in[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q         <= '0;
      addr_q        <= '0;
      ready_q       <= 1'b1;
      valid_q       <= 1'b0;
      data_out_q    <= '0;
      address_out_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      if (state_d == S_RESP) begin
        data_out_q    <= data_out_d;
        address_out_q <= addr_d;
      end
    end
  end

  assign data_out    = data_out_q;
  assign address_out = address_out_q;
  assign valid       = valid_q;
  assign ready       = ready_q;

`ifndef SYNTHESIS
  int cycle_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_q <= 0;
    end else begin
      cycle_q <= cycle_q + 1;
    end
  end

  always @(posedge clock) begin
    if (scan && (cycle_q >= SCAN_CYCLES_MIN) && (cycle_q <= SCAN_CYCLES_MAX)) begin
      $display("scan cyc=%0d state=%0d cnt=%0d ready=%b valid=%b address_out=%h",
               cycle_q, state_q, cnt_q, ready_q, valid_q, address_out_q);
    end
  end
`endif

endmodule

// File: tb/tb_multi_cycle_memory_responder.sv
// Directed bench for multi_cycle_memory_responder with a response scoreboard.
module tb_multi_cycle_memory_responder;

  localparam int LAT     = 3;
`ifdef MEM_LATENCY_JITTER_EN
  localparam int LAT_MAX = LAT + 3;
`else
  localparam int LAT_MAX = LAT;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          acc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        read, write, scan;
  logic [3:0]  byte_en;
  logic [31:0] address_in, data_in;
  logic [31:0] data_out, address_out;
  logic        valid, ready;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          issued = 0;
  int          dropped = 0;
  int          resp_cnt = 0;
  exp_t        sbq[$];
  logic [31:0] mem_m[int];

  multi_cycle_memory_responder dut (
    .clock(clock), .reset(reset), .read(read), .write(write),
    .byte_en(byte_en), .address_in(address_in), .data_in(data_in),
    .data_out(data_out), .address_out(address_out),
    .valid(valid), .ready(ready), .scan(scan)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Response checker: every valid pulse pops the oldest expected response
  always @(negedge clock) begin
    if (reset === 1'b1 && valid === 1'b1) begin
      total++;
      assert (sbq.size() > 0) else begin
        bad++; $error("FAIL spurious_valid got addr=%h exp=no response", address_out);
      end
      if (sbq.size() > 0) begin
        exp_t e;
        int   lat;
        e   = sbq.pop_front();
        lat = cyc - e.acc + 1;
        resp_cnt++;
        total++;
        assert (data_out === e.data) else begin
          bad++; $error("FAIL resp_data got=%h exp=%h", data_out, e.data);
        end
        total++;
        assert (address_out === e.addr) else begin
          bad++; $error("FAIL resp_addr got=%h exp=%h", address_out, e.addr);
        end
        total++;
        assert (lat >= LAT && lat <= LAT_MAX) else begin
          bad++; $error("FAIL resp_latency got=%0d exp=%0d..%0d", lat, LAT, LAT_MAX);
        end
        total++;
        assert (ready === 1'b1) else begin
          bad++; $error("FAIL resp_ready got=%b exp=1", ready);
        end
      end
    end
  end

  // Called at a negedge; holds the request until ready, returns at the negedge after acceptance
  task automatic issue(input logic rd, input logic wr, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] data);
    int          n;
    int          idx;
    logic [31:0] w;
    exp_t        e;
    read = rd; write = wr; byte_en = be; address_in = addr; data_in = data;
    n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    total++;
    assert (ready === 1'b1) else begin
      bad++; $error("FAIL ready_timeout got=%b exp=1", ready);
    end
    idx = int'(addr[13:0]);
    if (wr) begin
      w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
      for (int b = 0; b < 4; b++) begin
        if (be[b]) w[b*8 +: 8] = data[b*8 +: 8];
      end
      mem_m[idx] = w;
    end
    e.addr = addr;
    e.data = mem_m.exists(idx) ? mem_m[idx] : 32'hxxxx_xxxx;
    e.acc  = cyc + 1;
    sbq.push_back(e);
    issued++;
    @(negedge clock);
    read = 1'b0; write = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    total++;
    assert (sbq.size() == 0) else begin
      bad++; $error("FAIL drain_timeout got=%0d pending exp=0", sbq.size());
    end
    @(negedge clock);
  endtask

  task automatic check_idle(input string tag);
    total++;
    assert (ready === 1'b1) else begin
      bad++; $error("FAIL %s_ready got=%b exp=1", tag, ready);
    end
    total++;
    assert (valid === 1'b0) else begin
      bad++; $error("FAIL %s_valid got=%b exp=0", tag, valid);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nvalid;
    int a;
    reset = 1'b0; read = 1'b0; write = 1'b0; scan = 1'b0;
    byte_en = 4'h0; address_in = '0; data_in = '0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Reset state and quiet idle period
    check_idle("reset");
    total++;
    assert (data_out === 32'h0) else begin
      bad++; $error("FAIL reset_data got=%h exp=0", data_out);
    end
    total++;
    assert (address_out === 32'h0) else begin
      bad++; $error("FAIL reset_addr got=%h exp=0", address_out);
    end
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (valid === 1'b1) nvalid++;
    end
    total++;
    assert (nvalid == 0) else begin
      bad++; $error("FAIL idle_valid got=%0d exp=0", nvalid);
    end

    // Read latency with ready profile
    issue(1'b0, 1'b1, 4'hF, 32'd5, 32'hDEADBEEF);
    drain();
    issue(1'b1, 1'b0, 4'h0, 32'd5, 32'h0);
`ifndef MEM_LATENCY_JITTER_EN
    total++;
    assert (ready === 1'b0 && valid === 1'b0) else begin
      bad++; $error("FAIL lat_c1 got=r%b v%b exp=r0 v0", ready, valid);
    end
    @(negedge clock);
    total++;
    assert (ready === 1'b0 && valid === 1'b0) else begin
      bad++; $error("FAIL lat_c2 got=r%b v%b exp=r0 v0", ready, valid);
    end
    @(negedge clock);
    total++;
    assert (valid === 1'b1 && data_out === 32'hDEADBEEF && address_out === 32'd5) else begin
      bad++; $error("FAIL lat_c3 got=v%b %h@%h exp=v1 deadbeef@5", valid, data_out, address_out);
    end
`endif
    drain();
    total++;
    assert (valid === 1'b0 && data_out === 32'hDEADBEEF) else begin
      bad++; $error("FAIL hold_data got=v%b %h exp=v0 deadbeef", valid, data_out);
    end

    // Byte-lane write, zero-enable write, read-back
    issue(1'b0, 1'b1, 4'hF, 32'd7, 32'hAAAAAAAA);
    issue(1'b0, 1'b1, 4'b0101, 32'd7, 32'h11223344);
    drain();
    total++;
    assert (data_out === 32'hAA22AA44) else begin
      bad++; $error("FAIL byte_write got=%h exp=aa22aa44", data_out);
    end
    issue(1'b0, 1'b1, 4'b0000, 32'd7, 32'h55555555);
    issue(1'b1, 1'b0, 4'h0, 32'd7, 32'h0);
    drain();

    // Back-to-back reads with the request held across RESP
    for (int i = 1; i <= 3; i++) issue(1'b0, 1'b1, 4'hF, 32'(i), 32'h1000_0000 * i + 32'(i));
    drain();
    a = resp_cnt;
    for (int i = 1; i <= 3; i++) issue(1'b1, 1'b0, 4'h0, 32'(i), 32'h0);
    drain();
    total++;
    assert (resp_cnt - a == 3) else begin
      bad++; $error("FAIL b2b_count got=%0d exp=3", resp_cnt - a);
    end

    // Simultaneous read and write returns the post-write word
    issue(1'b0, 1'b1, 4'hF, 32'd12, 32'h0F0F0F0F);
    issue(1'b1, 1'b1, 4'b1100, 32'd12, 32'hCAFE1234);
    drain();

    // Address wrap
    issue(1'b0, 1'b1, 4'hF, 32'd9, 32'h99990009);
    issue(1'b1, 1'b0, 4'h0, 32'h0000_4009, 32'h0);
    issue(1'b0, 1'b1, 4'hF, 32'h8000_4000, 32'h12345678);
    issue(1'b1, 1'b0, 4'h0, 32'd0, 32'h0);
    drain();

    // Reset during WAIT drops the response but keeps the write
    issue(1'b0, 1'b1, 4'hF, 32'd20, 32'hBEEF0020);
    reset = 1'b0;
    void'(sbq.pop_back());
    dropped++;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_idle("midreset");
    for (int i = 0; i < 6; i++) @(negedge clock);
    issue(1'b1, 1'b0, 4'h0, 32'd20, 32'h0);
    drain();

    // Random mix over a pre-written window
    for (int i = 32; i < 40; i++) issue(1'b0, 1'b1, 4'hF, 32'(i), $urandom);
    for (int i = 0; i < 20; i++) begin
      int op;
      op = int'($urandom_range(0, 2));
      issue(op != 1, op != 0, 4'($urandom_range(0, 15)), 32'($urandom_range(32, 39)), $urandom);
      if ($urandom_range(0, 1) == 1) @(negedge clock);
    end
    drain();
    total++;
    assert (resp_cnt == issued - dropped) else begin
      bad++; $error("FAIL resp_total got=%0d exp=%0d", resp_cnt, issued - dropped);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
